// File: rtl/cpu_vram_writer.sv
// Snoops 68000 write cycles aimed at the main screen buffer and replays them as
// byte writes into the VRAM during the wrWindow slots granted by the fetch path.
module cpu_vram_writer #(
  parameter logic [23:0] FB_BASE    = 24'h3FA700,
  parameter int          FB_BYTES   = 21888,
  parameter int          VRAM_AW    = 15,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               pixClk,
  input  logic               Reset,
  input  logic [23:1]        cpuAddr,
  input  logic [15:0]        cpuData,
  input  logic               ncpuAS,
  input  logic               ncpuUDS,
  input  logic               ncpuLDS,
  input  logic               cpuRnW,
  input  logic               wrWindow,
  output logic [VRAM_AW-1:0] vramAddr,
  output logic [7:0]         vramDataOut,
  output logic               vramDataOE,
  output logic               nvramWE,
  output logic               busy,
  output logic               overflow
);

  localparam int EW = VRAM_AW + 18;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [1:0]         asSync, udsSync, ldsSync, rnwSync;
  logic               armed, wrCond, capture, inWindow;
  logic [23:0]        byteAddr, offset;
  logic               vld_p0;
  logic [EW-1:0]      entry_p0;
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [PW:0]        wrPtr, rdPtr;
  logic               empty, full, push, pop;
  logic [EW-1:0]      headEntry;
  logic [VRAM_AW-1:0] headOff;
  logic [15:0]        headData;
  logic               headUb, headLb;
  state_t             state, stateNext;
  logic [VRAM_AW-1:0] addrNext;
  logic [7:0]         dataNext;
  logic               oeNext, weNext;
  logic               curUpper, upperNext, upperDone, doneNext;

  always_ff @(posedge pixClk or posedge Reset) begin
    if (Reset) begin
      asSync  <= 2'b11;
      udsSync <= 2'b11;
      ldsSync <= 2'b11;
      rnwSync <= 2'b11;
      armed   <= 1'b1;
    end else begin
      asSync  <= {asSync[0], ncpuAS};
      udsSync <= {udsSync[0], ncpuUDS};
      ldsSync <= {ldsSync[0], ncpuLDS};
      rnwSync <= {rnwSync[0], cpuRnW};
      if (asSync[1])
        armed <= 1'b1;
      else if (capture)
        armed <= 1'b0;
    end
  end

  // One capture per AS assertion; a second DS pulse under the same AS is ignored.
  assign wrCond   = ~asSync[1] & (~udsSync[1] | ~ldsSync[1]) & ~rnwSync[1];
  assign capture  = wrCond & armed;
  assign byteAddr = {cpuAddr, 1'b0};
  assign offset   = byteAddr - FB_BASE;
  assign inWindow = (byteAddr >= FB_BASE) && (offset < 24'(FB_BYTES));

  // Stage p0: captured, decoded write waiting to be pushed
  always_ff @(posedge pixClk or posedge Reset) begin
    if (Reset) vld_p0 <= 1'b0;
    else       vld_p0 <= capture & inWindow;
  end

  always_ff @(posedge pixClk) begin
    if (capture)
      entry_p0 <= {offset[VRAM_AW-1:0], cpuData, ~udsSync[1], ~ldsSync[1]};
  end

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign push  = vld_p0 & (~full | pop);

  always_ff @(posedge pixClk) begin
    if (push) mem[wrPtr[PW-1:0]] <= entry_p0;
  end

  always_ff @(posedge pixClk or posedge Reset) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (vld_p0 && full && !pop) overflow <= 1'b1;
    end
  end

  assign headEntry = mem[rdPtr[PW-1:0]];
  assign headOff   = headEntry[EW-1 -: VRAM_AW];
  assign headData  = headEntry[17:2];
  assign headUb    = headEntry[1];
  assign headLb    = headEntry[0];

  always_ff @(posedge pixClk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      vramAddr    <= '0;
      vramDataOut <= '0;
      vramDataOE  <= 1'b0;
      nvramWE     <= 1'b1;
      curUpper    <= 1'b0;
      upperDone   <= 1'b0;
    end else begin
      state       <= stateNext;
      vramAddr    <= addrNext;
      vramDataOut <= dataNext;
      vramDataOE  <= oeNext;
      nvramWE     <= weNext;
      curUpper    <= upperNext;
      upperDone   <= doneNext;
    end
  end

  // upperDone remembers a finished upper byte when the window closed before the lower one.
  always_comb begin
    stateNext = state;
    addrNext  = vramAddr;
    dataNext  = vramDataOut;
    oeNext    = vramDataOE;
    weNext    = 1'b1;
    upperNext = curUpper;
    doneNext  = upperDone;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && wrWindow) begin
          stateNext = SETUP;
          oeNext    = 1'b1;
          if (headUb && !upperDone) begin
            upperNext = 1'b1;
            addrNext  = headOff;
            dataNext  = headData[15:8];
          end else begin
            upperNext = 1'b0;
            addrNext  = headOff + VRAM_AW'(1);
            dataNext  = headData[7:0];
          end
        end
      end
      SETUP: begin
        stateNext = STROBE;
        weNext    = 1'b0;
      end
      STROBE: stateNext = HOLD;
      HOLD: begin
        if (curUpper && headLb) begin
          if (wrWindow) begin
            stateNext = SETUP;
            addrNext  = vramAddr + VRAM_AW'(1);
            dataNext  = headData[7:0];
            upperNext = 1'b0;
          end else begin
            stateNext = IDLE;
            oeNext    = 1'b0;
            doneNext  = 1'b1;
          end
        end else begin
          stateNext = IDLE;
          oeNext    = 1'b0;
          doneNext  = 1'b0;
          pop       = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = ~empty | (state != IDLE);

endmodule
